// File: rtl/axi_ad9364_data_chk_pkg.sv
// Shared definitions for the AD9364 receive pattern checker: FSM states, default pattern
// words (matching the dac-side generator) and counter widths.
package axi_ad9364_data_chk_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StLocked = 2'd2
  } chk_state_e;

  localparam logic [11:0] DefPatI1 = 12'o2064;
  localparam logic [11:0] DefPatQ1 = 12'o1753;
  localparam logic [11:0] DefPatI2 = 12'o4402;
  localparam logic [11:0] DefPatQ2 = 12'o1337;

  localparam int unsigned ErrCntW    = 16;
  localparam int unsigned SampleCntW = 32;
  localparam int unsigned RunCntW    = 8;

  function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/axi_ad9364_chk_cmp.sv
// Per-channel comparator: flags whether one I/Q pair equals pattern phase A or phase B.
module axi_ad9364_chk_cmp #(
  parameter logic [11:0] PAT_IA = 12'o2064,
  parameter logic [11:0] PAT_QA = 12'o1753,
  parameter logic [11:0] PAT_IB = 12'o4402,
  parameter logic [11:0] PAT_QB = 12'o1337
) (
  input  logic [11:0] data_i,
  input  logic [11:0] data_q,
  output logic        match_a,
  output logic        match_b
);

  assign match_a = (data_i == PAT_IA) && (data_q == PAT_QA);
  assign match_b = (data_i == PAT_IB) && (data_q == PAT_QB);

endmodule

// File: rtl/axi_ad9364_data_chk.sv
// Receive-side I/Q pattern checker: acquires A/B phase, locks, counts errors, flags loss of sync.
// Defining AD9364_CHK_CAPTURE_EN adds chk_cap_data/chk_cap_valid (first mismatched sample).
module axi_ad9364_data_chk
  import axi_ad9364_data_chk_pkg::*;
#(
  parameter logic [11:0] PAT_I1   = DefPatI1,
  parameter logic [11:0] PAT_Q1   = DefPatQ1,
  parameter logic [11:0] PAT_I2   = DefPatI2,
  parameter logic [11:0] PAT_Q2   = DefPatQ2,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned OOS_CNT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adc_valid,
  input  logic [11:0]           adc_data_i1,
  input  logic [11:0]           adc_data_q1,
  input  logic [11:0]           adc_data_i2,
  input  logic [11:0]           adc_data_q2,
  input  logic                  adc_r1_mode,
  input  logic                  chk_enable,
  input  logic                  chk_clear,
  output logic                  chk_locked,
  output logic                  chk_err,
  output logic                  chk_oos,
  output logic [ErrCntW-1:0]    chk_err_cnt,
  output logic [SampleCntW-1:0] chk_sample_cnt
`ifdef AD9364_CHK_CAPTURE_EN
  ,
  output logic [47:0]           chk_cap_data,
  output logic                  chk_cap_valid
`endif
);

  localparam logic [RunCntW-1:0] LockLim = RunCntW'(LOCK_CNT);
  localparam logic [RunCntW-1:0] OosLim  = RunCntW'(OOS_CNT);

  chk_state_e            state_q;
  logic                  phase_q;  // next expected phase, 0: A, 1: B
  logic                  mode_q;
  logic                  err_q;
  logic                  oos_q;
  logic [RunCntW-1:0]    run_q;
  logic [RunCntW-1:0]    miss_q;
  logic [ErrCntW-1:0]    err_cnt_q;
  logic [SampleCntW-1:0] sample_cnt_q;

  logic c1_a, c1_b, c2_a, c2_b;
  logic match_a, match_b, match_exp;
  logic search_hit, hit_phase;

  axi_ad9364_chk_cmp #(
    .PAT_IA (PAT_I1),
    .PAT_QA (PAT_Q1),
    .PAT_IB (PAT_I2),
    .PAT_QB (PAT_Q2)
  ) u_cmp_ch1 (
    .data_i  (adc_data_i1),
    .data_q  (adc_data_q1),
    .match_a (c1_a),
    .match_b (c1_b)
  );

  axi_ad9364_chk_cmp #(
    .PAT_IA (PAT_I1),
    .PAT_QA (PAT_Q1),
    .PAT_IB (PAT_I2),
    .PAT_QB (PAT_Q2)
  ) u_cmp_ch2 (
    .data_i  (adc_data_i2),
    .data_q  (adc_data_q2),
    .match_a (c2_a),
    .match_b (c2_b)
  );

  assign match_a   = c1_a && (adc_r1_mode || c2_a);
  assign match_b   = c1_b && (adc_r1_mode || c2_b);
  assign match_exp = phase_q ? match_b : match_a;

  // A fresh run may start on either phase; a run in progress must follow the alternation.
  always_comb begin
    search_hit = 1'b0;
    hit_phase  = phase_q;
    if (run_q == '0) begin
      if (match_a) begin
        search_hit = 1'b1;
        hit_phase  = 1'b0;
      end else if (match_b) begin
        search_hit = 1'b1;
        hit_phase  = 1'b1;
      end
    end else begin
      search_hit = match_exp;
    end
  end

`ifdef AD9364_CHK_CAPTURE_EN
  logic [47:0] cap_data_q;
  logic        cap_valid_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      mode_q       <= 1'b0;
      err_q        <= 1'b0;
      oos_q        <= 1'b0;
      run_q        <= '0;
      miss_q       <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
`ifdef AD9364_CHK_CAPTURE_EN
      cap_data_q   <= '0;
      cap_valid_q  <= 1'b0;
`endif
    end else begin
      mode_q <= adc_r1_mode;
      err_q  <= 1'b0;
      if (!chk_enable) begin
        state_q <= StIdle;
        run_q   <= '0;
        miss_q  <= '0;
      end else if (state_q == StIdle) begin
        state_q <= StSearch;
        run_q   <= '0;
        miss_q  <= '0;
      end else if (adc_r1_mode != mode_q) begin
        state_q <= StSearch;
        run_q   <= '0;
        miss_q  <= '0;
      end else if (adc_valid) begin
        if (state_q == StLocked) begin
          phase_q      <= ~phase_q;
          sample_cnt_q <= sample_cnt_q + 1'b1;
          if (match_exp) begin
            miss_q <= '0;
          end else begin
            err_q     <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
`ifdef AD9364_CHK_CAPTURE_EN
            if (!cap_valid_q) begin
              cap_data_q  <= {adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2};
              cap_valid_q <= 1'b1;
            end
`endif
            if (miss_q + 1'b1 == OosLim) begin
              state_q <= StSearch;
              oos_q   <= 1'b1;
              run_q   <= '0;
              miss_q  <= '0;
            end else begin
              miss_q <= miss_q + 1'b1;
            end
          end
        end else if (search_hit) begin
          phase_q <= ~hit_phase;
          if (run_q + 1'b1 == LockLim) begin
            state_q <= StLocked;
            run_q   <= '0;
            miss_q  <= '0;
          end else begin
            run_q <= run_q + 1'b1;
          end
        end else begin
          run_q <= '0;
        end
      end
      // Clear overrides any count or flag update made in the same cycle.
      if (chk_clear) begin
        err_cnt_q    <= '0;
        sample_cnt_q <= '0;
        oos_q        <= 1'b0;
`ifdef AD9364_CHK_CAPTURE_EN
        cap_data_q   <= '0;
        cap_valid_q  <= 1'b0;
`endif
      end
    end
  end

  assign chk_locked     = (state_q == StLocked);
  assign chk_err        = err_q;
  assign chk_oos        = oos_q;
  assign chk_err_cnt    = err_cnt_q;
  assign chk_sample_cnt = sample_cnt_q;
`ifdef AD9364_CHK_CAPTURE_EN
  assign chk_cap_data   = cap_data_q;
  assign chk_cap_valid  = cap_valid_q;
`endif

endmodule

// File: tb/tb_axi_ad9364_data_chk.sv
// Bench for axi_ad9364_data_chk: vector table, directed corner cases, randomized traffic vs model,
// and a saturation run on a second instance with a long out-of-sync threshold.
module tb_axi_ad9364_data_chk;

  localparam logic [11:0] PI1 = 12'o2064;
  localparam logic [11:0] PQ1 = 12'o1753;
  localparam logic [11:0] PI2 = 12'o4402;
  localparam logic [11:0] PQ2 = 12'o1337;
  localparam int LOCKN = 8;
  localparam int OOSN  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, adc_valid, r1, en, clr;
  logic [11:0] i1, q1, i2, q2;
  logic        chk_locked, chk_err, chk_oos;
  logic [15:0] chk_err_cnt;
  logic [31:0] chk_sample_cnt;
`ifdef AD9364_CHK_CAPTURE_EN
  logic [47:0] chk_cap_data;
  logic        chk_cap_valid;
`endif

  axi_ad9364_data_chk dut (
    .clk            (clk),
    .rst            (rst),
    .adc_valid      (adc_valid),
    .adc_data_i1    (i1),
    .adc_data_q1    (q1),
    .adc_data_i2    (i2),
    .adc_data_q2    (q2),
    .adc_r1_mode    (r1),
    .chk_enable     (en),
    .chk_clear      (clr),
    .chk_locked     (chk_locked),
    .chk_err        (chk_err),
    .chk_oos        (chk_oos),
    .chk_err_cnt    (chk_err_cnt),
    .chk_sample_cnt (chk_sample_cnt)
`ifdef AD9364_CHK_CAPTURE_EN
    ,
    .chk_cap_data   (chk_cap_data),
    .chk_cap_valid  (chk_cap_valid)
`endif
  );

  // Second instance: a long miss threshold lets errors reach saturation without losing lock.
  logic        s_rst, s_valid;
  logic [11:0] s_i1, s_q1;
  logic        s_locked, s_err, s_oos;
  logic [15:0] s_err_cnt;
  logic [31:0] s_sample_cnt;
`ifdef AD9364_CHK_CAPTURE_EN
  logic [47:0] s_cap_data;
  logic        s_cap_valid;
`endif

  axi_ad9364_data_chk #(
    .OOS_CNT (255)
  ) dut_sat (
    .clk            (clk),
    .rst            (s_rst),
    .adc_valid      (s_valid),
    .adc_data_i1    (s_i1),
    .adc_data_q1    (s_q1),
    .adc_data_i2    (12'h000),
    .adc_data_q2    (12'h000),
    .adc_r1_mode    (1'b1),
    .chk_enable     (1'b1),
    .chk_clear      (1'b0),
    .chk_locked     (s_locked),
    .chk_err        (s_err),
    .chk_oos        (s_oos),
    .chk_err_cnt    (s_err_cnt),
    .chk_sample_cnt (s_sample_cnt)
`ifdef AD9364_CHK_CAPTURE_EN
    ,
    .chk_cap_data   (s_cap_data),
    .chk_cap_valid  (s_cap_valid)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_active, m_locked, m_ph, m_r1, m_err, m_oos, m_capv;
  int          m_run, m_miss;
  int unsigned m_err_cnt, m_smp;
  logic [47:0] m_cap;

  function automatic int ch_phase(input logic [11:0] di, input logic [11:0] dq);
    if (di == PI1 && dq == PQ1) return 0;
    if (di == PI2 && dq == PQ2) return 1;
    return 2;
  endfunction

  task automatic model_update();
    int p1, p2, hit;
    bit ma, mb, ok, mode_chg;
    if (rst) begin
      m_active = 0; m_locked = 0; m_ph = 0; m_r1 = 0; m_err = 0; m_oos = 0; m_capv = 0;
      m_run = 0; m_miss = 0; m_err_cnt = 0; m_smp = 0; m_cap = '0;
      return;
    end
    p1 = ch_phase(i1, q1);
    p2 = ch_phase(i2, q2);
    ma = (p1 == 0) && (r1 || p2 == 0);
    mb = (p1 == 1) && (r1 || p2 == 1);
    mode_chg = (r1 != m_r1);
    m_r1  = r1;
    m_err = 0;
    if (!en) begin
      m_active = 0; m_locked = 0;
    end else if (!m_active) begin
      m_active = 1; m_run = 0; m_miss = 0;
    end else if (mode_chg) begin
      m_locked = 0; m_run = 0; m_miss = 0;
    end else if (adc_valid) begin
      if (m_locked) begin
        ok = m_ph ? mb : ma;
        m_ph = !m_ph;
        m_smp++;
        if (ok) m_miss = 0;
        else begin
          m_err = 1;
          if (m_err_cnt < 65535) m_err_cnt++;
          if (!m_capv) begin m_cap = {i1, q1, i2, q2}; m_capv = 1; end
          m_miss++;
          if (m_miss == OOSN) begin m_locked = 0; m_oos = 1; m_run = 0; m_miss = 0; end
        end
      end else begin
        if (m_run == 0) hit = ma ? 0 : (mb ? 1 : -1);
        else hit = (m_ph ? mb : ma) ? int'(m_ph) : -1;
        if (hit < 0) m_run = 0;
        else begin
          m_run++;
          m_ph = (hit == 0);
          if (m_run == LOCKN) begin m_locked = 1; m_run = 0; m_miss = 0; end
        end
      end
    end
    if (clr) begin m_err_cnt = 0; m_smp = 0; m_oos = 0; m_capv = 0; m_cap = '0; end
  endtask

  task automatic check_all();
    chk("locked", chk_locked, m_locked);
    chk("err", chk_err, m_err);
    chk("oos", chk_oos, m_oos);
    chk("err_cnt", chk_err_cnt, m_err_cnt);
    chk("sample_cnt", chk_sample_cnt, m_smp);
`ifdef AD9364_CHK_CAPTURE_EN
    chk("cap_valid", chk_cap_valid, m_capv);
    chk("cap_data", chk_cap_data, m_capv ? m_cap : 48'h0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // ---------------- stimulus helpers ----------------
  bit          tx_ph;
  logic [47:0] last_sample;

  task automatic put(input bit v, input bit ph, input bit bad1, input bit bad2);
    adc_valid = v;
    i1 = bad1 ? 12'o0000 : (ph ? PI2 : PI1);
    q1 = ph ? PQ2 : PQ1;
    i2 = ph ? PI2 : PI1;
    q2 = bad2 ? ~(ph ? PQ2 : PQ1) : (ph ? PQ2 : PQ1);
    last_sample = {i1, q1, i2, q2};
  endtask

  task automatic send(input bit bad1, input bit bad2);
    put(1'b1, tx_ph, bad1, bad2);
    tick();
    tx_ph = !tx_ph;
  endtask

  task automatic nosend();
    adc_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    bit valid;
    bit bad;
    bit e_locked;
    bit e_err;
    int e_cnt;
    bit e_oos;
  } vec_t;

  function automatic vec_t mk(bit v, bit b, bit l, bit e, int c, bit o);
    vec_t r;
    r.valid = v; r.bad = b; r.e_locked = l; r.e_err = e; r.e_cnt = c; r.e_oos = o;
    return r;
  endfunction

  vec_t        tbl[24];
  logic [47:0] exp_cap;
  int          nbad, k;
  bit          bad;
  bit          s_ph;

  initial begin
    rst = 1; en = 0; clr = 0; r1 = 1; adc_valid = 0;
    i1 = '0; q1 = '0; i2 = '0; q2 = '0; tx_ph = 0; last_sample = '0; exp_cap = '0;
    s_rst = 1; s_valid = 0; s_i1 = '0; s_q1 = '0; s_ph = 0;

    for (int i = 0; i < 7; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 1, 1, 1, 0);
    tbl[10] = mk(1, 0, 1, 0, 1, 0);
    tbl[11] = mk(1, 1, 1, 1, 2, 0);
    tbl[12] = mk(1, 1, 1, 1, 3, 0);
    tbl[13] = mk(1, 1, 1, 1, 4, 0);
    tbl[14] = mk(1, 1, 0, 1, 5, 1);
    tbl[15] = mk(0, 0, 0, 0, 5, 1);
    for (int i = 16; i < 23; i++) tbl[i] = mk(1, 0, 0, 0, 5, 1);
    tbl[23] = mk(1, 0, 1, 0, 5, 1);

    // Reset state
    @(negedge clk);
    tick(); tick(); tick();
    chk("reset_locked", chk_locked, 0);
    chk("reset_err_cnt", chk_err_cnt, 0);
    chk("reset_sample_cnt", chk_sample_cnt, 0);
    chk("reset_oos", chk_oos, 0);
    rst = 0;
    en  = 1;
    nosend();

    // Lock, single error, loss of sync and relock in r1 mode
    for (int i = 0; i < 24; i++) begin
      if (tbl[i].valid) send(tbl[i].bad, 1'b0);
      else nosend();
      chk($sformatf("tbl%0d_locked", i), chk_locked, tbl[i].e_locked);
      chk($sformatf("tbl%0d_err", i), chk_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_err_cnt", i), chk_err_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_oos", i), chk_oos, tbl[i].e_oos);
    end

    // Disable, clear, restart on phase B; long clean stream with gaps
    en = 0; nosend();
    chk("idle_unlocked", chk_locked, 0);
    clr = 1; nosend(); clr = 0;
    en = 1; nosend();
    tx_ph = 1;
    for (int i = 0; i < LOCKN - 1; i++) send(0, 0);
    chk("phb_pre_lock", chk_locked, 0);
    send(0, 0);
    chk("phb_lock", chk_locked, 1);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) nosend();
      send(0, 0);
    end
    chk("clean_err_cnt", chk_err_cnt, 0);
    chk("clean_sample_cnt", chk_sample_cnt, 1000);

    // Single corrupted sample
    send(1, 0);
    chk("single_err", chk_err, 1);
    chk("single_err_cnt", chk_err_cnt, 1);
    chk("single_locked", chk_locked, 1);
    send(0, 0);
    chk("single_err_pulse", chk_err, 0);

    // Four consecutive errors drop lock, relock keeps oos
    for (int i = 0; i < OOSN; i++) send(1, 0);
    chk("oos_err_cnt", chk_err_cnt, 5);
    chk("oos_locked", chk_locked, 0);
    chk("oos_flag", chk_oos, 1);
    for (int i = 0; i < LOCKN; i++) send(0, 0);
    chk("relock", chk_locked, 1);
    chk("relock_oos", chk_oos, 1);

    // Clear coinciding with an error sample wins
    clr = 1; send(1, 0); clr = 0;
    chk("clr_err_cnt", chk_err_cnt, 0);
    chk("clr_oos", chk_oos, 0);
    chk("clr_sample_cnt", chk_sample_cnt, 0);
    send(0, 0);

    // 2-channel mode: ch2 corruption counts, mode toggle drops lock without oos
    r1 = 0; nosend();
    chk("mode_drop", chk_locked, 0);
    for (int i = 0; i < LOCKN; i++) send(0, 0);
    chk("ch2_lock", chk_locked, 1);
    send(0, 1);
    exp_cap = last_sample;
    send(0, 0);
    send(0, 1);
    send(0, 0);
    chk("ch2_err_cnt", chk_err_cnt, 2);
    chk("ch2_locked", chk_locked, 1);
`ifdef AD9364_CHK_CAPTURE_EN
    chk("cap_first_bad", chk_cap_data, exp_cap);
    chk("cap_valid_set", chk_cap_valid, 1);
`endif
    for (int i = 0; i < OOSN; i++) send(0, 1);
    chk("ch2_oos", chk_oos, 1);
    for (int i = 0; i < LOCKN; i++) send(0, 0);
    chk("ch2_relock", chk_locked, 1);
    r1 = 1; nosend();
    chk("toggle_unlocked", chk_locked, 0);
    chk("toggle_oos_kept", chk_oos, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(499) == 0);
      en  = ($urandom_range(99) != 0);
      clr = ($urandom_range(79) == 0);
      if ($urandom_range(149) == 0) r1 = !r1;
      if ($urandom_range(39) == 0) tx_ph = !tx_ph;
      if ($urandom_range(3) != 0) begin
        send($urandom_range(11) == 0, $urandom_range(11) == 0);
      end else begin
        nosend();
      end
    end
    rst = 0; clr = 0; en = 0; adc_valid = 0;

    // Saturation run on the second instance
    @(negedge clk); s_rst = 0;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < LOCKN; i++) begin
      s_valid = 1; s_i1 = s_ph ? PI2 : PI1; s_q1 = s_ph ? PQ2 : PQ1;
      @(posedge clk); @(negedge clk);
      s_ph = !s_ph;
    end
    chk("sat_lock", s_locked, 1);
    nbad = 0; k = 0;
    while (nbad < 65540) begin
      bad  = (k % 255) != 254;
      s_i1 = bad ? 12'o0000 : (s_ph ? PI2 : PI1);
      s_q1 = s_ph ? PQ2 : PQ1;
      @(posedge clk); @(negedge clk);
      s_ph = !s_ph;
      if (bad) nbad++;
      if (bad && nbad == 65534) chk("sat_pre", s_err_cnt, 16'hFFFE);
      k++;
    end
    chk("sat_hold", s_err_cnt, 16'hFFFF);
    chk("sat_locked", s_locked, 1);
    chk("sat_samples", s_sample_cnt, k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
